// File: rtl/adrv9009_rhb2_sched_if.sv
// Stream bundle for the RHB2 scheduler: I/Q sample input and decimated I/Q output,
// each with its own valid/ready handshake.
interface adrv9009_rhb2_sched_if;
   logic signed [15:0] in_i;
   logic signed [15:0] in_q;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] out_i;
   logic signed [15:0] out_q;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_i, in_q, in_valid, out_ready,
      input  in_ready, out_i, out_q, out_valid
   );

   modport slave (
      input  in_i, in_q, in_valid, out_ready,
      output in_ready, out_i, out_q, out_valid
   );
endinterface

// File: rtl/adrv9009_rhb2_sched.sv
// RHB2 half-band decimate-by-2: one shared pre-add/MAC walks the 6 symmetric taps for I, then Q.
// Build option RHB2_SAT_EN: saturate the rounded result instead of wrapping it to 16 bits.
//
// state | meaning
// IDLE  | waiting for the first sample of a pair
// HALF  | waiting for the second sample of a pair
// MAC_I | six MAC steps over the I delay line
// MAC_Q | six MAC steps over the Q delay line
// OUT   | result pair presented until out_ready
module adrv9009_rhb2_sched (
   input  logic clk,
   input  logic reset,
   adrv9009_rhb2_sched_if.slave bus
);

   typedef enum logic [2:0] {IDLE, HALF, MAC_I, MAC_Q, OUT} state_t;

   state_t             state_q, state_d;
   logic        [2:0]  step_q, step_d;
   logic signed [35:0] acc_q, acc_d;
   logic signed [15:0] xi_q [19];
   logic signed [15:0] xi_d [19];
   logic signed [15:0] xq_q [19];
   logic signed [15:0] xq_d [19];
   logic signed [15:0] out_i_q, out_i_d, out_q_q, out_q_d;
   logic               out_valid_q, out_valid_d;
   logic               rdy_q, rdy_d;

   logic               accept;
   logic signed [15:0] tap_lo, tap_hi, coef;
   logic signed [16:0] pre;
   logic signed [32:0] prod;
   logic signed [35:0] acc_sum, rnd;
   logic signed [15:0] res;
   logic               rnd_unused;

   // in_ready is forced low combinationally while reset is held
   assign bus.in_ready  = reset && rdy_q;
   assign bus.out_i     = out_i_q;
   assign bus.out_q     = out_q_q;
   assign bus.out_valid = out_valid_q;
   assign accept        = bus.in_valid && bus.in_ready;

   always_comb begin
      tap_lo = '0;
      tap_hi = '0;
      coef   = '0;
      for (int k = 0; k < 5; k++) begin
         if (step_q == 3'(k)) begin
            tap_lo = (state_q == MAC_Q) ? xq_q[2*k]      : xi_q[2*k];
            tap_hi = (state_q == MAC_Q) ? xq_q[18 - 2*k] : xi_q[18 - 2*k];
         end
      end
      if (step_q == 3'd5) tap_lo = (state_q == MAC_Q) ? xq_q[9] : xi_q[9];
      case (step_q)
         3'd0:    coef = 16'sd104;
         3'd1:    coef = -16'sd406;
         3'd2:    coef = 16'sd1120;
         3'd3:    coef = -16'sd2802;
         3'd4:    coef = 16'sd10188;
         3'd5:    coef = 16'sd16384;
         default: coef = '0;
      endcase
   end

   assign pre     = {tap_lo[15], tap_lo} + {tap_hi[15], tap_hi};
   assign prod    = $signed({{16{pre[16]}}, pre}) * $signed({{17{coef[15]}}, coef});
   assign acc_sum = acc_q + {{3{prod[32]}}, prod};
   assign rnd     = acc_sum + 36'sd16384;

`ifdef RHB2_SAT_EN
   logic signed [20:0] r_full;
   assign r_full     = rnd[35:15];
   assign res        = (r_full > 21'sd32767)  ? 16'sd32767 :
                       (r_full < -21'sd32768) ? -16'sd32768 : r_full[15:0];
   assign rnd_unused = ^rnd[14:0];
`else
   assign res        = rnd[30:15];
   assign rnd_unused = ^{rnd[35:31], rnd[14:0]};
`endif

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      acc_d       = acc_q;
      xi_d        = xi_q;
      xq_d        = xq_q;
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: if (accept) state_d = HALF;
         HALF: if (accept) begin
            state_d = MAC_I;
            acc_d   = '0;
            step_d  = '0;
         end
         MAC_I: if (step_q == 3'd5) begin
            out_i_d = res;
            state_d = MAC_Q;
            acc_d   = '0;
            step_d  = '0;
         end else begin
            acc_d  = acc_sum;
            step_d = step_q + 3'd1;
         end
         MAC_Q: if (step_q == 3'd5) begin
            out_q_d     = res;
            out_valid_d = 1'b1;
            state_d     = OUT;
            acc_d       = '0;
            step_d      = '0;
         end else begin
            acc_d  = acc_sum;
            step_d = step_q + 3'd1;
         end
         OUT: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         xi_d[0] = bus.in_i;
         xq_d[0] = bus.in_q;
         for (int k = 1; k < 19; k++) begin
            xi_d[k] = xi_q[k-1];
            xq_d[k] = xq_q[k-1];
         end
      end

      rdy_d = (state_d == IDLE) || (state_d == HALF);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         step_q      <= '0;
         acc_q       <= '0;
         for (int k = 0; k < 19; k++) begin
            xi_q[k] <= '0;
            xq_q[k] <= '0;
         end
         out_i_q     <= '0;
         out_q_q     <= '0;
         out_valid_q <= 1'b0;
         rdy_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         acc_q       <= acc_d;
         xi_q        <= xi_d;
         xq_q        <= xq_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         out_valid_q <= out_valid_d;
         rdy_q       <= rdy_d;
      end
   end

endmodule

// File: tb/tb_adrv9009_rhb2_sched.sv
// Directed bench for the RHB2 scheduler: table of I/Q pairs with hand-computed outputs,
// plus hand-written latency, backpressure and mid-MAC reset sequences.
module tb_adrv9009_rhb2_sched;

   typedef struct {
      logic signed [15:0] a_i, a_q, b_i, b_q;
      logic               chk;
      logic signed [15:0] e_i, e_q;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl [46];
   int   even_seq [11];
   int   dc_neg;

   adrv9009_rhb2_sched_if bus ();

   adrv9009_rhb2_sched dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic signed [15:0] si, input logic signed [15:0] sq);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("in_ready_timeout", 0, 1);
      bus.in_i     = si;
      bus.in_q     = sq;
      bus.in_valid = 1'b1;
      @(posedge clk);
   endtask

   // Returns the number of negedges after the accepting edge at which out_valid was first seen.
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat++;
      end while (!bus.out_valid && lat < 60);
      if (lat >= 60) check("out_valid_timeout", 0, 1);
   endtask

   task automatic run_table(input int lo, input int hi);
      int lat;
      for (int n = lo; n <= hi; n++) begin
         push(tbl[n].a_i, tbl[n].a_q);
         push(tbl[n].b_i, tbl[n].b_q);
         wait_out(lat);
         check($sformatf("tbl[%0d].valid", n), int'(bus.out_valid), 1);
         if (tbl[n].chk) begin
            check($sformatf("tbl[%0d].out_i", n), int'(bus.out_i), int'(tbl[n].e_i));
            check($sformatf("tbl[%0d].out_q", n), int'(bus.out_q), int'(tbl[n].e_q));
         end
      end
   endtask

   initial begin
      int lat;
      logic stable;

      even_seq = '{104, -406, 1120, -2802, 10188, 10188, -2802, 1120, -406, 104, 0};
`ifdef RHB2_SAT_EN
      dc_neg = -32768;
`else
      dc_neg = 32744;
`endif
      for (int n = 0; n < 46; n++)
         tbl[n] = '{a_i: 0, a_q: 0, b_i: 0, b_q: 0, chk: 1'b1, e_i: 0, e_q: 0};
      // I impulse on even phase, Q impulse on odd phase
      tbl[0].b_i = 16'sd32767;
      tbl[0].a_q = 16'sd32767;
      for (int n = 0; n < 11; n++) begin
         tbl[n].e_i = 16'(even_seq[n]);
         tbl[n].e_q = (n == 4) ? 16'sd16384 : 16'sd0;
      end
      // swapped: I odd phase, Q even phase
      tbl[11].a_i = 16'sd32767;
      tbl[11].b_q = 16'sd32767;
      for (int n = 0; n < 11; n++) begin
         tbl[11+n].e_i = (n == 4) ? 16'sd16384 : 16'sd0;
         tbl[11+n].e_q = 16'(even_seq[n]);
      end
      // DC levels; only steady-state outputs are checked
      for (int n = 0; n < 12; n++) begin
         tbl[22+n] = '{a_i: 16'sd16384, a_q: 0, b_i: 16'sd16384, b_q: 0,
                       chk: (n >= 9), e_i: 16'sd16396, e_q: 0};
         tbl[34+n] = '{a_i: -16'sd32768, a_q: -16'sd32768, b_i: -16'sd32768, b_q: -16'sd32768,
                       chk: (n >= 9), e_i: 16'(dc_neg), e_q: 16'(dc_neg)};
      end

      reset         = 1'b0;
      bus.in_i      = '0;
      bus.in_q      = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_i", int'(bus.out_i), 0);
      check("rst_out_q", int'(bus.out_q), 0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", int'(bus.in_ready), 1);

      // pair split by an idle gap in HALF, then held under backpressure
      push(16'sd1000, 16'sd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("half_wait_ready", int'(bus.in_ready), 1);
      push(16'sd2000, -16'sd30000);
      wait_out(lat);
      check("latency", lat, 13);
      check("bp_out_i", int'(bus.out_i), 6);
      check("bp_out_q", int'(bus.out_q), -95);
      stable = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_i != 16'sd6 || bus.out_q != -16'sd95 || bus.in_ready)
            stable = 1'b0;
      end
      check("bp_stable", int'(stable), 1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_one_transfer", int'(bus.out_valid), 0);
      check("bp_ready_after", int'(bus.in_ready), 1);

      // reset pulse during MAC_Q step 3
      push(16'sd0, 16'sd0);
      push(16'sd32767, 16'sd0);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      check("mac_in_ready", int'(bus.in_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mrst_out_valid", int'(bus.out_valid), 0);
      check("mrst_out_i", int'(bus.out_i), 0);
      check("mrst_out_q", int'(bus.out_q), 0);
      check("mrst_in_ready", int'(bus.in_ready), 1);

      run_table(0, 45);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
